// File: rtl/fc1_fifo_ctrl_if.sv
// fc1_fifo_ctrl_if: handshake and FIFO-side signals of the FC1 output FIFO controller.
// The abort signal is present only when FC1_FIFO_ABORT_EN is defined.
interface fc1_fifo_ctrl_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUMBER_OF_WM = 84,
  parameter int CNT_BITS     = $clog2(NUMBER_OF_WM + 1)
);
  logic                  start;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] fifo_data_in;
  logic                  fifo_enable;
  logic [CNT_BITS-1:0]   fill_count;
  logic                  fifo_full_valid;
  logic                  consume_done;
  logic                  busy;
  logic                  frame_done;
  logic                  start_err;
`ifdef FC1_FIFO_ABORT_EN
  logic                  abort;
  modport slave (input start, in_valid, in_data, consume_done, abort,
                 output in_ready, fifo_data_in, fifo_enable, fill_count, fifo_full_valid, busy, frame_done, start_err);
  modport master (output start, in_valid, in_data, consume_done, abort,
                  input in_ready, fifo_data_in, fifo_enable, fill_count, fifo_full_valid, busy, frame_done, start_err);
`else
  modport slave (input start, in_valid, in_data, consume_done,
                 output in_ready, fifo_data_in, fifo_enable, fill_count, fifo_full_valid, busy, frame_done, start_err);
  modport master (output start, in_valid, in_data, consume_done,
                  input in_ready, fifo_data_in, fifo_enable, fill_count, fifo_full_valid, busy, frame_done, start_err);
`endif
endinterface

// File: rtl/fc1_fifo_ctrl.sv
// fc1_fifo_ctrl: loads the FC1 output shift FIFO and holds it until FC2 has consumed the frame.
// Optional FC1_FIFO_ABORT_EN adds a synchronous abort that returns to IDLE from any state.
module fc1_fifo_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUMBER_OF_WM = 84,
  parameter int CNT_BITS     = $clog2(NUMBER_OF_WM + 1)
) (
  input logic clk,
  input logic rst_n,
  fc1_fifo_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;
  localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(NUMBER_OF_WM - 1);
  state_t                state_q, state_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  en_q, en_d, done_q, done_d, err_q, err_d;
  logic                  kill, accept, full_valid, release_ok;
`ifdef FC1_FIFO_ABORT_EN
  assign kill = bus.abort;
`else
  assign kill = 1'b0;
`endif
  always_comb begin
    full_valid = (state_q == HOLD) & ~en_q;
    accept     = (state_q == FILL) & bus.in_valid & ~kill;
    release_ok = full_valid & bus.consume_done;
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_d     = accept ? bus.in_data : data_q;
    en_d       = accept;
    done_d     = release_ok & ~kill;
    err_d      = err_q | (bus.start & ~kill & ((state_q == FILL) | ((state_q == HOLD) & ~release_ok)));
    if (kill) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == IDLE && bus.start) begin
      state_d = FILL;
      cnt_d   = '0;
    end else if (accept) begin
      cnt_d   = cnt_q + 1'b1;
      state_d = (cnt_q == LAST) ? HOLD : FILL;
    end else if (release_ok) begin
      cnt_d   = '0;
      state_d = bus.start ? FILL : IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      en_q    <= en_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  assign bus.in_ready        = state_q == FILL;
  assign bus.busy            = state_q != IDLE;
  assign bus.fifo_full_valid = full_valid;
  assign bus.fifo_data_in    = data_q;
  assign bus.fifo_enable     = en_q;
  assign bus.fill_count      = cnt_q;
  assign bus.frame_done      = done_q;
  assign bus.start_err       = err_q;
endmodule

// File: tb/tb_fc1_fifo_ctrl.sv
// tb_fc1_fifo_ctrl: directed checks of the FC1 FIFO controller against a shift-FIFO model.
module tb_fc1_fifo_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  logic [31:0] fifo_m [0:83];
  fc1_fifo_ctrl_if #(.DATA_WIDTH(32), .NUMBER_OF_WM(84)) bus ();
  fc1_fifo_ctrl #(.DATA_WIDTH(32), .NUMBER_OF_WM(84)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.fifo_enable) begin
      for (int i = 0; i < 83; i++) fifo_m[i] <= fifo_m[i+1];
      fifo_m[83] <= bus.fifo_data_in;
      en_cnt <= en_cnt + 1;
    end
  end
  task automatic start_frame();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic push(input int first, input int last);
    for (int v = first; v <= last; v++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = v;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 32'hDEAD_BEEF;
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if ({bus.busy, bus.in_ready, bus.fifo_enable, bus.fifo_full_valid, bus.frame_done, bus.start_err} !== 6'b0) begin errors++; $display("FAIL reset_flags got %b exp 000000", {bus.busy, bus.in_ready, bus.fifo_enable, bus.fifo_full_valid, bus.frame_done, bus.start_err}); end
    checks++; if (bus.fill_count !== 7'd0 || bus.fifo_data_in !== 32'd0) begin errors++; $display("FAIL reset_regs count %0d data %0h exp 0 0", bus.fill_count, bus.fifo_data_in); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_idle busy %b ready %b exp 0 0", bus.busy, bus.in_ready); end
  endtask
  task automatic test_fill_contiguous();
    int base, bad;
    base = en_cnt;
    start_frame();
    checks++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1 || bus.fill_count !== 7'd0) begin errors++; $display("FAIL fill_enter busy %b ready %b count %0d exp 1 1 0", bus.busy, bus.in_ready, bus.fill_count); end
    push(1, 83);
    checks++; if (bus.fill_count !== 7'd83 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL fill_83 count %0d ready %b exp 83 1", bus.fill_count, bus.in_ready); end
    push(84, 84);
    checks++; if (bus.fill_count !== 7'd84 || bus.in_ready !== 1'b0 || bus.fifo_enable !== 1'b1 || bus.fifo_full_valid !== 1'b0) begin errors++; $display("FAIL hold_entry count %0d ready %b en %b fv %b exp 84 0 1 0", bus.fill_count, bus.in_ready, bus.fifo_enable, bus.fifo_full_valid); end
    @(negedge clk);
    checks++; if (bus.fifo_full_valid !== 1'b1 || bus.fifo_enable !== 1'b0) begin errors++; $display("FAIL full_valid fv %b en %b exp 1 0", bus.fifo_full_valid, bus.fifo_enable); end
    checks++; if (en_cnt - base !== 84) begin errors++; $display("FAIL push_count got %0d exp 84", en_cnt - base); end
    bad = 0;
    for (int i = 0; i < 84; i++) if (fifo_m[i] !== 32'(i + 1)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL fifo_contents out_1 %0d out_84 %0d bad %0d exp 1 84 0", fifo_m[0], fifo_m[83], bad); end
    bus.consume_done = 1'b1;
    @(negedge clk);
    bus.consume_done = 1'b0;
    checks++; if (bus.frame_done !== 1'b1 || bus.busy !== 1'b0 || bus.fill_count !== 7'd0) begin errors++; $display("FAIL release done %b busy %b count %0d exp 1 0 0", bus.frame_done, bus.busy, bus.fill_count); end
    @(negedge clk);
    checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL done_pulse got %b exp 0", bus.frame_done); end
  endtask
  task automatic test_toggle();
    int base, bad;
    base = en_cnt;
    start_frame();
    for (int v = 1; v <= 84; v++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = v;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = 32'hDEAD_BEEF;
      checks++; if (bus.fifo_enable !== 1'b1 || bus.fifo_data_in !== 32'(v)) begin errors++; $display("FAIL toggle_push%0d en %b data %0h exp 1 %0h", v, bus.fifo_enable, bus.fifo_data_in, v); end
      if (v < 84) begin
        @(negedge clk);
        checks++; if (bus.fifo_enable !== 1'b0 || bus.fill_count !== 7'(v)) begin errors++; $display("FAIL toggle_gap%0d en %b count %0d exp 0 %0d", v, bus.fifo_enable, bus.fill_count, v); end
      end
    end
    bus.consume_done = 1'b1;
    @(negedge clk);
    checks++; if (bus.frame_done !== 1'b0 || bus.fifo_full_valid !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL early_consume done %b fv %b busy %b exp 0 1 1", bus.frame_done, bus.fifo_full_valid, bus.busy); end
    checks++; if (en_cnt - base !== 84) begin errors++; $display("FAIL toggle_count got %0d exp 84", en_cnt - base); end
    bad = 0;
    for (int i = 0; i < 84; i++) if (fifo_m[i] !== 32'(i + 1)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL toggle_contents bad %0d exp 0", bad); end
    @(negedge clk);
    bus.consume_done = 1'b0;
    checks++; if (bus.frame_done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL toggle_release done %b busy %b exp 1 0", bus.frame_done, bus.busy); end
  endtask
  task automatic test_back_to_back();
    start_frame();
    push(1, 84);
    @(negedge clk);
    bus.consume_done = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.consume_done = 1'b0;
    bus.start = 1'b0;
    checks++; if (bus.frame_done !== 1'b1 || bus.busy !== 1'b1 || bus.in_ready !== 1'b1 || bus.fill_count !== 7'd0) begin errors++; $display("FAIL b2b done %b busy %b ready %b count %0d exp 1 1 1 0", bus.frame_done, bus.busy, bus.in_ready, bus.fill_count); end
    checks++; if (bus.start_err !== 1'b0) begin errors++; $display("FAIL b2b_err got %b exp 0", bus.start_err); end
  endtask
  task automatic test_start_err();
    push(1, 40);
    checks++; if (bus.fill_count !== 7'd40 || bus.start_err !== 1'b0) begin errors++; $display("FAIL err_pre count %0d err %b exp 40 0", bus.fill_count, bus.start_err); end
    start_frame();
    checks++; if (bus.start_err !== 1'b1 || bus.fill_count !== 7'd40 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL err_set err %b count %0d ready %b exp 1 40 1", bus.start_err, bus.fill_count, bus.in_ready); end
    push(41, 84);
    @(negedge clk);
    checks++; if (bus.fill_count !== 7'd84 || bus.fifo_full_valid !== 1'b1 || bus.start_err !== 1'b1) begin errors++; $display("FAIL err_full count %0d fv %b err %b exp 84 1 1", bus.fill_count, bus.fifo_full_valid, bus.start_err); end
    checks++; if (fifo_m[0] !== 32'd1 || fifo_m[83] !== 32'd84) begin errors++; $display("FAIL err_contents out_1 %0d out_84 %0d exp 1 84", fifo_m[0], fifo_m[83]); end
    bus.consume_done = 1'b1;
    @(negedge clk);
    bus.consume_done = 1'b0;
    checks++; if (bus.frame_done !== 1'b1 || bus.busy !== 1'b0 || bus.start_err !== 1'b1) begin errors++; $display("FAIL err_sticky done %b busy %b err %b exp 1 0 1", bus.frame_done, bus.busy, bus.start_err); end
  endtask
  task automatic test_async_reset();
    start_frame();
    push(1, 50);
    checks++; if (bus.fill_count !== 7'd50 || bus.fifo_enable !== 1'b1) begin errors++; $display("FAIL pre_reset count %0d en %b exp 50 1", bus.fill_count, bus.fifo_enable); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({bus.busy, bus.in_ready, bus.fifo_enable, bus.fifo_full_valid, bus.frame_done, bus.start_err} !== 6'b0) begin errors++; $display("FAIL async_flags got %b exp 000000", {bus.busy, bus.in_ready, bus.fifo_enable, bus.fifo_full_valid, bus.frame_done, bus.start_err}); end
    checks++; if (bus.fill_count !== 7'd0 || bus.fifo_data_in !== 32'd0) begin errors++; $display("FAIL async_regs count %0d data %0h exp 0 0", bus.fill_count, bus.fifo_data_in); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL post_reset busy %b ready %b exp 0 0", bus.busy, bus.in_ready); end
    start_frame();
    checks++; if (bus.in_ready !== 1'b1 || bus.fill_count !== 7'd0) begin errors++; $display("FAIL post_reset_start ready %b count %0d exp 1 0", bus.in_ready, bus.fill_count); end
  endtask
`ifdef FC1_FIFO_ABORT_EN
  task automatic test_abort();
    int base, bad;
    push(1, 30);
    checks++; if (bus.fill_count !== 7'd30) begin errors++; $display("FAIL abort_pre count %0d exp 30", bus.fill_count); end
    bus.abort = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 32'd999;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.in_valid = 1'b0;
    base = en_cnt;
    checks++; if (bus.fifo_enable !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.fill_count !== 7'd0 || bus.frame_done !== 1'b0) begin errors++; $display("FAIL abort en %b busy %b ready %b count %0d done %b exp 0 0 0 0 0", bus.fifo_enable, bus.busy, bus.in_ready, bus.fill_count, bus.frame_done); end
    @(negedge clk);
    checks++; if (en_cnt !== base || bus.frame_done !== 1'b0) begin errors++; $display("FAIL abort_nopush pushes %0d done %b exp 0 0", en_cnt - base, bus.frame_done); end
    start_frame();
    push(1, 84);
    @(negedge clk);
    checks++; if (en_cnt - base !== 84 || bus.fifo_full_valid !== 1'b1) begin errors++; $display("FAIL abort_refill pushes %0d fv %b exp 84 1", en_cnt - base, bus.fifo_full_valid); end
    bad = 0;
    for (int i = 0; i < 84; i++) if (fifo_m[i] !== 32'(i + 1)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL abort_contents bad %0d exp 0", bad); end
  endtask
`endif
  initial begin
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.consume_done = 1'b0;
`ifdef FC1_FIFO_ABORT_EN
    bus.abort = 1'b0;
`endif
    test_reset();
    test_fill_contiguous();
    test_toggle();
    test_back_to_back();
    test_start_err();
    test_async_reset();
`ifdef FC1_FIFO_ABORT_EN
    test_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
